// File: rtl/vbank_rot_if.sv
// vbank_rot_if: bundle of the vector-bank access signals.
//   Vector read port A : i_a_valid, i_a -> o_a_ready, o_rd_valid, o_rd
//   Vector write port B: i_b_valid, i_b, i_wd, i_we -> o_b_ready
//   External port      : i_ex_req, i_ex_we, i_ex_a, i_ex_wd -> o_ex_gnt, o_ex_rvalid, o_ex_rd
// master drives requests (client side), slave is the bank.
interface vbank_rot_if #(
  parameter int LANES  = 12,
  parameter int DATA_W = 25,
  parameter int EA_W   = 10
);
  logic                    i_a_valid;
  logic [EA_W-1:0]         i_a;
  logic                    o_a_ready;
  logic                    o_rd_valid;
  logic [LANES*DATA_W-1:0] o_rd;

  logic                    i_b_valid;
  logic [EA_W-1:0]         i_b;
  logic [LANES*DATA_W-1:0] i_wd;
  logic [LANES-1:0]        i_we;
  logic                    o_b_ready;

  logic                    i_ex_req;
  logic                    i_ex_we;
  logic [EA_W-1:0]         i_ex_a;
  logic [DATA_W-1:0]       i_ex_wd;
  logic                    o_ex_gnt;
  logic                    o_ex_rvalid;
  logic [DATA_W-1:0]       o_ex_rd;

  modport master (
    output i_a_valid, i_a,
    input  o_a_ready, o_rd_valid, o_rd,
    output i_b_valid, i_b, i_wd, i_we,
    input  o_b_ready,
    output i_ex_req, i_ex_we, i_ex_a, i_ex_wd,
    input  o_ex_gnt, o_ex_rvalid, o_ex_rd
  );

  modport slave (
    input  i_a_valid, i_a,
    output o_a_ready, o_rd_valid, o_rd,
    input  i_b_valid, i_b, i_wd, i_we,
    output o_b_ready,
    input  i_ex_req, i_ex_we, i_ex_a, i_ex_wd,
    output o_ex_gnt, o_ex_rvalid, o_ex_rd
  );
endinterface

// File: rtl/vbank_rot.sv
// vbank_rot: rotating vector memory bank.
// LANES single-element lanes; element address ea maps to lane ea%LANES, row ea/LANES,
// so a LANES-wide vector may start at any element. Vector read (A) and vector write (B)
// run in parallel; a single-element external port borrows the lanes through an arbiter
// that stalls the vector ports for one cycle once a request has waited STARVE_MAX cycles.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : vbank_rot_if.slave (vector A/B ports and external port)
module vbank_rot #(
  parameter int LANES      = 12,
  parameter int DATA_W     = 25,
  parameter int ROW_W      = 6,
  parameter int IDX_W      = $clog2(LANES),
  parameter int EA_W       = ROW_W + IDX_W,
  parameter int STARVE_MAX = 8
) (
  input logic        clk,
  input logic        rst_n,
  vbank_rot_if.slave bus
);

  localparam int DEPTH = 2 ** ROW_W;
  localparam int SW    = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]    STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [IDX_W-1:0] LANES_I    = IDX_W'(LANES);

  function automatic logic [ROW_W-1:0] ea_row(input logic [EA_W-1:0] ea);
    return ROW_W'(ea / EA_W'(LANES));
  endfunction

  function automatic logic [IDX_W-1:0] ea_idx(input logic [EA_W-1:0] ea);
    return IDX_W'(ea % EA_W'(LANES));
  endfunction

  logic [DATA_W-1:0] mem_q [LANES][DEPTH];

  logic [ROW_W-1:0] a_row, b_row, ex_row;
  logic [IDX_W-1:0] a_idx, b_idx, ex_idx;

  assign a_row  = ea_row(bus.i_a);
  assign a_idx  = ea_idx(bus.i_a);
  assign b_row  = ea_row(bus.i_b);
  assign b_idx  = ea_idx(bus.i_b);
  assign ex_row = ea_row(bus.i_ex_a);
  assign ex_idx = ea_idx(bus.i_ex_a);

  // Arbiter
  logic [SW-1:0] starve_q, starve_d;
  logic          ex_gnt, a_fire, b_fire;

  always_comb begin
    ex_gnt = bus.i_ex_req &
             (!(bus.i_a_valid | bus.i_b_valid) | (starve_q == STARVE_TOP));
    a_fire = bus.i_a_valid & !ex_gnt;
    b_fire = bus.i_b_valid & !ex_gnt;
    if (!bus.i_ex_req || ex_gnt) begin
      starve_d = '0;
    end else if (starve_q != STARVE_TOP) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Lane mapping. For lane l and a vector whose first element sits in lane idx,
  // the vector slice held by l is (l - idx) mod LANES; lanes below idx hold the
  // tail of the vector, which lives one row further on (row wraps at DEPTH).
  logic [LANES*DATA_W-1:0] rd_d;
  logic [LANES-1:0]        lane_we;
  logic [ROW_W-1:0]        lane_row [LANES];
  logic [DATA_W-1:0]       lane_wd  [LANES];

  always_comb begin : lane_map
    logic [IDX_W-1:0] lidx;
    logic [IDX_W-1:0] aj;
    logic [IDX_W-1:0] bj;
    logic [ROW_W-1:0] ar;
    logic [ROW_W-1:0] br;
    lidx    = '0;
    aj      = '0;
    bj      = '0;
    ar      = '0;
    br      = '0;
    rd_d    = '0;
    lane_we = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_row[l] = '0;
      lane_wd[l]  = '0;
    end
    for (int l = 0; l < LANES; l++) begin
      lidx = IDX_W'(l);

      if (lidx >= a_idx) begin
        aj = lidx - a_idx;
        ar = a_row;
      end else begin
        aj = lidx + LANES_I - a_idx;
        ar = a_row + ROW_W'(1);
      end
      // Rotation is undone here so slice 0 of the registered word is element i_a.
      rd_d[aj*DATA_W +: DATA_W] = mem_q[l][ar];

      if (lidx >= b_idx) begin
        bj = lidx - b_idx;
        br = b_row;
      end else begin
        bj = lidx + LANES_I - b_idx;
        br = b_row + ROW_W'(1);
      end
      lane_we[l]  = b_fire & bus.i_we[bj];
      lane_row[l] = br;
      lane_wd[l]  = bus.i_wd[bj*DATA_W +: DATA_W];

      // A granted external access excludes vector traffic in the same cycle.
      if (ex_gnt && bus.i_ex_we && (lidx == ex_idx)) begin
        lane_we[l]  = 1'b1;
        lane_row[l] = ex_row;
        lane_wd[l]  = bus.i_ex_wd;
      end
    end
  end

  // Storage is intentionally not reset. Reads above see the pre-edge contents,
  // giving read-before-write on a same-cycle collision.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (lane_we[l]) begin
        mem_q[l][lane_row[l]] <= lane_wd[l];
      end
    end
  end

  logic                    rd_valid_q;
  logic [LANES*DATA_W-1:0] rd_q;
  logic                    ex_rvalid_q;
  logic [DATA_W-1:0]       ex_rd_q;
  logic                    ex_rd_fire;

  assign ex_rd_fire = ex_gnt & !bus.i_ex_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_q        <= '0;
      ex_rvalid_q <= 1'b0;
      ex_rd_q     <= '0;
    end else begin
      starve_q    <= starve_d;
      rd_valid_q  <= a_fire;
      ex_rvalid_q <= ex_rd_fire;
      if (a_fire) begin
        rd_q <= rd_d;
      end
      if (ex_rd_fire) begin
        ex_rd_q <= mem_q[ex_idx][ex_row];
      end
    end
  end

  assign bus.o_ex_gnt    = ex_gnt;
  assign bus.o_a_ready   = !ex_gnt;
  assign bus.o_b_ready   = !ex_gnt;
  assign bus.o_rd_valid  = rd_valid_q;
  assign bus.o_rd        = rd_q;
  assign bus.o_ex_rvalid = ex_rvalid_q;
  assign bus.o_ex_rd     = ex_rd_q;

endmodule

// File: tb/tb_vbank_rot.sv
module tb_vbank_rot;
  localparam int L  = 12;
  localparam int DW = 25;
  localparam int EW = 10;
  localparam int NE = 768;
  localparam int VW = L * DW;

  typedef struct {
    int             op;    // 0 vec write, 1 vec read, 2 ex write, 3 ex read
    int             ea;
    logic [L-1:0]   we;
    logic [DW-1:0]  d;
    int             mode;  // write data: 0 value=ea, 1 d+j, 2 d in every slice
    logic [DW-1:0]  x0;    // required slice 0 / ex data
    bit             hx;
  } vec_t;

  typedef struct {
    logic [VW-1:0] d;
    logic [L-1:0]  m;
    int            ea;
    logic [DW-1:0] x0;
    bit            hx;
  } rexp_t;

  typedef struct {
    logic [DW-1:0] d;
    bit            m;
    int            ea;
    logic [DW-1:0] x0;
    bit            hx;
  } xexp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vbank_rot_if #(.LANES(L), .DATA_W(DW), .EA_W(EW)) bus ();

  vbank_rot #(
    .LANES(L), .DATA_W(DW), .ROW_W(6), .IDX_W(4), .EA_W(EW), .STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [DW-1:0] mdl [NE];
  bit            mdl_v [NE];
  rexp_t         rdq [$];
  xexp_t         xq [$];
  int            n_vec = 0;
  int            n_err = 0;
  vec_t          tbl [19];

  function automatic rexp_t predict(int base, bit hx, logic [DW-1:0] x0);
    rexp_t r;
    int e;
    r.d = '0;
    r.m = '0;
    for (int j = 0; j < L; j++) begin
      e = (base + j) % NE;
      r.d[j*DW +: DW] = mdl[e];
      r.m[j] = mdl_v[e];
    end
    r.ea = base;
    r.x0 = x0;
    r.hx = hx;
    return r;
  endfunction

  function automatic logic [VW-1:0] mk_data(int base, int mode, logic [DW-1:0] d);
    logic [VW-1:0] w;
    w = '0;
    for (int j = 0; j < L; j++) begin
      case (mode)
        0:       w[j*DW +: DW] = DW'((base + j) % NE);
        1:       w[j*DW +: DW] = d + DW'(j);
        default: w[j*DW +: DW] = d;
      endcase
    end
    return w;
  endfunction

  task automatic model_write(int base, logic [L-1:0] we, logic [VW-1:0] wd);
    int e;
    for (int j = 0; j < L; j++) begin
      if (we[j]) begin
        e = (base + j) % NE;
        mdl[e] = wd[j*DW +: DW];
        mdl_v[e] = 1'b1;
      end
    end
  endtask

  task automatic chk(string nm, logic [VW-1:0] got, logic [VW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_a_valid = 1'b0;
    bus.i_a       = '0;
    bus.i_b_valid = 1'b0;
    bus.i_b       = '0;
    bus.i_wd      = '0;
    bus.i_we      = '0;
    bus.i_ex_req  = 1'b0;
    bus.i_ex_we   = 1'b0;
    bus.i_ex_a    = '0;
    bus.i_ex_wd   = '0;
  endtask

  // One cycle of vector traffic; expected read data is taken from the model
  // before the write lands (read-before-write).
  task automatic vec_cycle(bit rd, int ra, bit hx, logic [DW-1:0] x0,
                           bit wr, int wa, logic [L-1:0] we, logic [VW-1:0] wd);
    bit ar, br;
    @(negedge clk);
    bus.i_a_valid = rd;
    bus.i_a       = EW'(ra);
    bus.i_b_valid = wr;
    bus.i_b       = EW'(wa);
    bus.i_we      = we;
    bus.i_wd      = wd;
    #1;
    ar = bus.o_a_ready;
    br = bus.o_b_ready;
    @(posedge clk);
    if (rd && ar) rdq.push_back(predict(ra, hx, x0));
    if (wr && br) model_write(wa, we, wd);
    #1;
    bus.i_a_valid = 1'b0;
    bus.i_b_valid = 1'b0;
  endtask

  task automatic ex_op(bit we, int ea, logic [DW-1:0] wd, bit hx, logic [DW-1:0] x0,
                       output int waited);
    bit got;
    xexp_t x;
    got = 1'b0;
    waited = 0;
    @(negedge clk);
    bus.i_ex_req = 1'b1;
    bus.i_ex_we  = we;
    bus.i_ex_a   = EW'(ea);
    bus.i_ex_wd  = wd;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (bus.o_ex_gnt) got = 1'b1;
      else begin
        @(negedge clk);
        waited++;
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL ex_gnt_timeout ea=%0d got=no_grant exp=grant", ea);
    end else begin
      @(posedge clk);
      if (we) begin
        mdl[ea] = wd;
        mdl_v[ea] = 1'b1;
      end else begin
        x.d = mdl[ea];
        x.m = mdl_v[ea];
        x.ea = ea;
        x.x0 = x0;
        x.hx = hx;
        xq.push_back(x);
      end
    end
    #1;
    bus.i_ex_req = 1'b0;
  endtask

  // Output monitor: pops the scoreboard whenever the bank presents data.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_rd_valid) begin
        n_vec++;
        if (rdq.size() == 0) begin
          n_err++;
          $display("FAIL rd_unexpected got=%0h exp=no_read", bus.o_rd);
        end else begin
          rexp_t e;
          bit bad;
          e = rdq.pop_front();
          bad = 1'b0;
          for (int j = 0; j < L; j++)
            if (e.m[j] && (bus.o_rd[j*DW +: DW] !== e.d[j*DW +: DW])) bad = 1'b1;
          if (bad) begin
            n_err++;
            $display("FAIL rd_data ea=%0d got=%0h exp=%0h mask=%0h", e.ea, bus.o_rd, e.d, e.m);
          end
          if (e.hx) begin
            n_vec++;
            if (bus.o_rd[DW-1:0] !== e.x0) begin
              n_err++;
              $display("FAIL rd_slice0 ea=%0d got=%0h exp=%0h", e.ea, bus.o_rd[DW-1:0], e.x0);
            end
          end
        end
      end
      if (bus.o_ex_rvalid) begin
        n_vec++;
        if (xq.size() == 0) begin
          n_err++;
          $display("FAIL ex_unexpected got=%0h exp=no_read", bus.o_ex_rd);
        end else begin
          xexp_t x;
          x = xq.pop_front();
          if (x.m && (bus.o_ex_rd !== x.d)) begin
            n_err++;
            $display("FAIL ex_rd ea=%0d got=%0h exp=%0h", x.ea, bus.o_ex_rd, x.d);
          end
          if (x.hx) begin
            n_vec++;
            if (bus.o_ex_rd !== x.x0) begin
              n_err++;
              $display("FAIL ex_rd_table ea=%0d got=%0h exp=%0h", x.ea, bus.o_ex_rd, x.x0);
            end
          end
        end
      end
    end
  end

  initial begin
    int waited;
    int ra, wa;
    bit rd, wr, gs, as;
    logic [L-1:0] we;
    logic [VW-1:0] wd;

    tbl[0]  = '{op:0, ea:0,   we:12'hFFF, d:25'd1,      mode:1, x0:25'd0,      hx:0};
    tbl[1]  = '{op:1, ea:0,   we:12'h000, d:25'd0,      mode:0, x0:25'd1,      hx:1};
    tbl[2]  = '{op:0, ea:0,   we:12'hFFF, d:25'd0,      mode:0, x0:25'd0,      hx:0};
    tbl[3]  = '{op:0, ea:12,  we:12'hFFF, d:25'd0,      mode:0, x0:25'd0,      hx:0};
    tbl[4]  = '{op:1, ea:5,   we:12'h000, d:25'd0,      mode:0, x0:25'd5,      hx:1};
    tbl[5]  = '{op:0, ea:13,  we:12'h003, d:25'h1AAAA,  mode:2, x0:25'd0,      hx:0};
    tbl[6]  = '{op:3, ea:12,  we:12'h000, d:25'd0,      mode:0, x0:25'd12,     hx:1};
    tbl[7]  = '{op:3, ea:13,  we:12'h000, d:25'd0,      mode:0, x0:25'h1AAAA,  hx:1};
    tbl[8]  = '{op:3, ea:14,  we:12'h000, d:25'd0,      mode:0, x0:25'h1AAAA,  hx:1};
    tbl[9]  = '{op:3, ea:15,  we:12'h000, d:25'd0,      mode:0, x0:25'd15,     hx:1};
    tbl[10] = '{op:0, ea:760, we:12'hFFF, d:25'd0,      mode:0, x0:25'd0,      hx:0};
    tbl[11] = '{op:1, ea:760, we:12'h000, d:25'd0,      mode:0, x0:25'd760,    hx:1};
    tbl[12] = '{op:1, ea:767, we:12'h000, d:25'd0,      mode:0, x0:25'd767,    hx:1};
    tbl[13] = '{op:1, ea:11,  we:12'h000, d:25'd0,      mode:0, x0:25'd11,     hx:1};
    tbl[14] = '{op:2, ea:100, we:12'h000, d:25'h0ABCDE, mode:0, x0:25'd0,      hx:0};
    tbl[15] = '{op:3, ea:100, we:12'h000, d:25'd0,      mode:0, x0:25'h0ABCDE, hx:1};
    tbl[16] = '{op:1, ea:95,  we:12'h000, d:25'd0,      mode:0, x0:25'd0,      hx:0};
    tbl[17] = '{op:0, ea:766, we:12'h801, d:25'h55,     mode:2, x0:25'd0,      hx:0};
    tbl[18] = '{op:1, ea:0,   we:12'h000, d:25'd0,      mode:0, x0:25'd0,      hx:1};

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rd_valid",  VW'(bus.o_rd_valid),  VW'(0));
    chk("rst_rd",        bus.o_rd,             VW'(0));
    chk("rst_ex_rvalid", VW'(bus.o_ex_rvalid), VW'(0));
    chk("rst_ex_rd",     VW'(bus.o_ex_rd),     VW'(0));
    chk("rst_a_ready",   VW'(bus.o_a_ready),   VW'(1));
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      case (tbl[i].op)
        0: vec_cycle(1'b0, 0, 1'b0, '0, 1'b1, tbl[i].ea, tbl[i].we,
                     mk_data(tbl[i].ea, tbl[i].mode, tbl[i].d));
        1: vec_cycle(1'b1, tbl[i].ea, tbl[i].hx, tbl[i].x0, 1'b0, 0, '0, '0);
        2: ex_op(1'b1, tbl[i].ea, tbl[i].d, 1'b0, '0, waited);
        default: begin
          ex_op(1'b0, tbl[i].ea, '0, tbl[i].hx, tbl[i].x0, waited);
          chk("ex_idle_wait", VW'(waited), VW'(0));
        end
      endcase
    end

    // Same-cycle read and write of the same elements returns the old data.
    vec_cycle(1'b0, 0, 1'b0, '0, 1'b1, 200, 12'hFFF, mk_data(200, 1, 25'h100));
    vec_cycle(1'b1, 200, 1'b1, 25'h100, 1'b1, 200, 12'hFFF, mk_data(200, 1, 25'h155));
    vec_cycle(1'b1, 200, 1'b1, 25'h155, 1'b0, 0, '0, '0);

    // Starvation: vector reads every cycle, two ex reads back to back.
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("starve_rvalid_c%0d", c), VW'(bus.o_ex_rvalid), VW'((c == 5) || (c == 10)));
      bus.i_a_valid = 1'b1;
      bus.i_a       = '0;
      bus.i_ex_req  = (c <= 9);
      bus.i_ex_we   = 1'b0;
      bus.i_ex_a    = (c <= 4) ? EW'(12) : EW'(13);
      #1;
      gs = bus.o_ex_gnt;
      as = bus.o_a_ready;
      chk($sformatf("starve_gnt_c%0d", c),   VW'(gs), VW'((c == 4) || (c == 9)));
      chk($sformatf("starve_ready_c%0d", c), VW'(as), VW'(!((c == 4) || (c == 9))));
      @(posedge clk);
      if (as) rdq.push_back(predict(0, 1'b0, '0));
      if (gs) begin
        xexp_t x;
        x.ea = (c <= 4) ? 12 : 13;
        x.d  = mdl[x.ea];
        x.m  = mdl_v[x.ea];
        x.hx = 1'b0;
        x.x0 = '0;
        xq.push_back(x);
      end
    end
    @(negedge clk);
    idle_inputs();

    for (int i = 0; i < 30; i++) begin
      ra = $urandom_range(0, NE - 1);
      wa = $urandom_range(0, NE - 1);
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      we = L'($urandom);
      for (int j = 0; j < L; j++) wd[j*DW +: DW] = DW'($urandom);
      vec_cycle(rd, ra, 1'b0, '0, wr, wa, we, wd);
      if ((i % 7) == 3) ex_op(1'b0, ra, '0, 1'b0, '0, waited);
    end

    // Reset lands while a read is being accepted: no o_rd_valid may follow.
    repeat (3) @(negedge clk);
    bus.i_a_valid = 1'b1;
    bus.i_a       = '0;
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    bus.i_a_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_rd_valid_hold", VW'(bus.o_rd_valid), VW'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rd_valid", VW'(bus.o_rd_valid), VW'(0));
    chk("post_rst_rd",       bus.o_rd,            VW'(0));

    repeat (3) @(negedge clk);
    chk("rd_queue_empty", VW'(rdq.size()), VW'(0));
    chk("ex_queue_empty", VW'(xq.size()),  VW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
